// File: rtl/sub_result_capture.sv
// Two-entry capture FIFO for 4-bit subtractor results {d, b_out, v}, with a sticky overflow flag.
// Define SUB_OVF_COUNT_EN to add the saturating ovf_cnt overflow event counter port.
module sub_result_capture #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_d,
  input  logic             in_b_out,
  input  logic             in_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_d,
  output logic             out_b_out,
  output logic             out_v,
  output logic             ovf_sticky,
  input  logic             ovf_clr
`ifdef SUB_OVF_COUNT_EN
  ,
  output logic [CNT_W-1:0] ovf_cnt
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic [3:0] d;
    logic       b_out;
    logic       v;
  } entry_t;

  logic [1:0] state_q, state_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       sticky_q, sticky_d;
  entry_t     mem_q [2];
  entry_t     head;
  logic       push, pop, ovf_push;

  // Handshake signals depend only on registered state, never on out_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign ovf_push  = push && in_v;

  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_d     = head.d;
  assign out_b_out = head.b_out;
  assign out_v     = head.v;
  assign ovf_sticky = sticky_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // A set from an overflowed push wins over a coincident clear.
  always_comb begin
    sticky_d = sticky_q;
    if (ovf_push)     sticky_d = 1'b1;
    else if (ovf_clr) sticky_d = 1'b0;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sticky_q <= sticky_d;
    end
  end

  // NOTE: storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{d: in_d, b_out: in_b_out, v: in_v};
  end

`ifdef SUB_OVF_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr)                          cnt_d = ovf_push ? CNT_ONE : '0;
    else if (ovf_push && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ovf_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sub_result_capture.sv
// Scoreboard bench for sub_result_capture: pushes are queued as expected entries and
// compared when the DUT hands them out; scenario tasks add inline handshake/flag checks.
module tb_sub_result_capture;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_d;
  logic             in_b_out;
  logic             in_v;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_d;
  logic             out_b_out;
  logic             out_v;
  logic             ovf_sticky;
  logic             ovf_clr;
`ifdef SUB_OVF_COUNT_EN
  logic [CNT_W-1:0] ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [5:0] sb [$];

  sub_result_capture #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_d       (in_d),
    .in_b_out   (in_b_out),
    .in_v       (in_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_d      (out_d),
    .out_b_out  (out_b_out),
    .out_v      (out_v),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
`ifdef SUB_OVF_COUNT_EN
    ,
    .ovf_cnt    (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock: at the falling edge compare any pop against the queue head and
  // record any accepted push, then return 1 time unit after the next rising edge.
  task automatic tick();
    logic [5:0] exp;
    @(negedge clk);
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: got out=%h with nothing expected", {out_d, out_b_out, out_v});
        end else begin
          exp = sb.pop_front();
          if ({out_d, out_b_out, out_v} !== exp) begin
            errors++;
            $display("FAIL sb_pop: got {d,b,v}=%h required %h", {out_d, out_b_out, out_v}, exp);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back({in_d, in_b_out, in_v});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [3:0] d, input logic b, input logic v);
    in_valid = valid;
    in_d     = d;
    in_b_out = b;
    in_v     = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({in_ready, out_valid, out_d, out_b_out, out_v, ovf_sticky} !== 9'b1_0_0000_0_0_0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b d=%h b=%b v=%b st=%b required 1 0 0 0 0 0",
               in_ready, out_valid, out_d, out_b_out, out_v, ovf_sticky);
    end
`ifdef SUB_OVF_COUNT_EN
    checks++;
    if (ovf_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", ovf_cnt); end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 4'h5, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_d !== 4'h5) begin
      errors++; $display("FAIL single_latency: got vld=%b d=%h required 1 5", out_valid, out_d);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_d !== 4'h0) begin
      errors++; $display("FAIL single_drain: got vld=%b d=%h required 0 0", out_valid, out_d);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'hC, 1'b1, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_d !== 4'h3) begin
      errors++; $display("FAIL fill_full: got rdy=%b d=%h required 0 3", in_ready, out_d);
    end
    drive(1'b1, 4'h7, 1'b0, 1'b1);   // ignored while full: no entry, no sticky
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_d !== 4'h3 || ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL fill_stall: got rdy=%b vld=%b d=%h st=%b required 0 1 3 0",
               in_ready, out_valid, out_d, ovf_sticky);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_d !== 4'hC || out_b_out !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL fill_second: got d=%h b=%b rdy=%b required C 1 1", out_d, out_b_out, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_empty: got vld=%b required 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] val;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      val = 4'((i * 5 + 2) % 16);
      drive(1'b1, val, i[0], 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_d !== val) begin
        errors++;
        $display("FAIL b2b_%0d: got vld=%b rdy=%b d=%h required 1 1 %h", i, out_valid, in_ready, out_d, val);
      end
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got vld=%b required 0", out_valid); end
  endtask

  task automatic test_sticky();
    out_ready = 1'b1;
    drive(1'b1, 4'h9, 1'b1, 1'b1);
    tick();
    checks++;
    if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set: got %b required 1", ovf_sticky); end
    ovf_clr = 1'b1;
    tick();
    checks++;
    if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_clr_vs_set: got %b required 1", ovf_sticky); end
`ifdef SUB_OVF_COUNT_EN
    checks++;
    if (ovf_cnt !== 2'd1) begin errors++; $display("FAIL cnt_clr_vs_push: got %0d required 1", ovf_cnt); end
`endif
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b required 0", ovf_sticky); end
`ifdef SUB_OVF_COUNT_EN
    checks++;
    if (ovf_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clear: got %0d required 0", ovf_cnt); end
`endif
    tick();
  endtask

`ifdef SUB_OVF_COUNT_EN
  task automatic test_saturation();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ovf_cnt !== 2'd3) begin errors++; $display("FAIL cnt_saturate: got %0d required 3", ovf_cnt); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 4'h9, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'h6, 1'b0, 1'b1);
    tick();
    checks++;
    if (in_ready !== 1'b0 || ovf_sticky !== 1'b1) begin
      errors++; $display("FAIL mid_prefill: got rdy=%b st=%b required 0 1", in_ready, ovf_sticky);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_d, out_b_out, out_v, ovf_sticky} !== 9'b1_0_0000_0_0_0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b vld=%b d=%h b=%b v=%b st=%b required 1 0 0 0 0 0",
               in_ready, out_valid, out_d, out_b_out, out_v, ovf_sticky);
    end
`ifdef SUB_OVF_COUNT_EN
    checks++;
    if (ovf_cnt !== '0) begin errors++; $display("FAIL mid_reset_cnt: got %0d required 0", ovf_cnt); end
`endif
    sb.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, 4'hA, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_d !== 4'hA) begin
      errors++; $display("FAIL mid_first_push: got vld=%b d=%h required 1 A", out_valid, out_d);
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_sticky();
`ifdef SUB_OVF_COUNT_EN
    test_saturation();
`endif
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
